// File: rtl/lives_pkg.sv
// Shared types and helpers for the multi-player lives controller.
// Player state enum, invuln counter width and net-delta saturating add.
package lives_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } player_state_t;

  localparam int INVULN_FRAMES_DEF = 60;
  localparam int INVULN_W = $clog2(INVULN_FRAMES_DEF + 1);

  function automatic int sat_add(
    input int cur,
    input int delta,
    input int max_v
  );
    int s;
    s = cur + delta;
    if (s < 0)
      s = 0;
    else if (s > max_v)
      s = max_v;
    return s;
  endfunction

endpackage

// File: rtl/lives_player_slot.sv
// One player's lives count, ALIVE/INVULN/DEAD FSM and invuln frame counter.
// In: clk, reset, clr, sof, freeze, inc, dbg_inc, hit, force_dec. Out: lives_o, invuln_o, dead_o, dead_next_o.
module lives_player_slot
  import lives_pkg::*;
#(
  parameter int LIVES_W       = 4,
  parameter int MAX_LIVES     = 9,
  parameter int INIT_LIVES    = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int CNT_W         = INVULN_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               sof,
  input  logic               freeze,
  input  logic               inc,
  input  logic               dbg_inc,
  input  logic               hit,
  input  logic               force_dec,
  output logic [LIVES_W-1:0] lives_o,
  output logic               invuln_o,
  output logic               dead_o,
  output logic               dead_next_o
);

  player_state_t      state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hit_acc;
  int                 delta;
  int                 nxt;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    hit_acc = 1'b0;
    delta   = 0;
    nxt     = 0;
    if (clr) begin
      state_d = ALIVE;
      lives_d = LIVES_W'(INIT_LIVES);
      cnt_d   = '0;
    end else if (!freeze && state_q != DEAD) begin
      // Hits only land while fully vulnerable; debug dec always lands.
      hit_acc = hit && (state_q == ALIVE);
      delta   = int'(inc) + int'(dbg_inc)
              - int'(hit_acc) - int'(force_dec);
      nxt     = sat_add(int'(lives_q), delta, MAX_LIVES);
      lives_d = LIVES_W'(nxt);
      if (nxt == 0) begin
        state_d = DEAD;
        cnt_d   = '0;
      end else if (hit_acc) begin
        // SOF coinciding with the hit is not counted.
        state_d = INVULN;
        cnt_d   = '0;
      end else if (state_q == INVULN && sof) begin
        if (cnt_q == CNT_W'(INVULN_FRAMES - 1)) begin
          state_d = ALIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ALIVE;
      lives_q <= LIVES_W'(INIT_LIVES);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lives_o     = lives_q;
  assign invuln_o    = (state_q == INVULN);
  assign dead_o      = (state_q == DEAD);
  assign dead_next_o = (state_d == DEAD);

endmodule

// File: rtl/lives_manager.sv
// Multi-player lives controller: per-player slots, debug switch edges, game-over/winner.
// In: clk, reset, start_of_frame, lives_reset, sw_inc, sw_dec, dbg_sel, powerup_inc, player_hit.
// Out: lives (packed), invulnerable, player_died, game_over, winner_valid, winner_id.
module lives_manager
  import lives_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int LIVES_W       = 4,
  parameter int MAX_LIVES     = 9,
  parameter int INIT_LIVES    = 3,
  parameter int INVULN_FRAMES = 60,
  localparam int SEL_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_of_frame,
  input  logic                           lives_reset,
  input  logic                           sw_inc,
  input  logic                           sw_dec,
  input  logic [SEL_W-1:0]               dbg_sel,
  input  logic [NUM_PLAYERS-1:0]         powerup_inc,
  input  logic [NUM_PLAYERS-1:0]         player_hit,
  output logic [NUM_PLAYERS*LIVES_W-1:0] lives,
  output logic [NUM_PLAYERS-1:0]         invulnerable,
  output logic [NUM_PLAYERS-1:0]         player_died,
  output logic                           game_over,
  output logic                           winner_valid,
  output logic [SEL_W-1:0]               winner_id
);

  localparam int CNT_W = $clog2(INVULN_FRAMES + 1);

  logic                   sw_inc_q, sw_inc_d;
  logic                   sw_dec_q, sw_dec_d;
  logic                   inc_edge, dec_edge;
  logic [NUM_PLAYERS-1:0] sel;
  logic [NUM_PLAYERS-1:0] dead_next;
  logic                   go_q, go_d;
  logic                   wv_q, wv_d;
  logic [SEL_W-1:0]       wid_q, wid_d;
  int                     alive_n;

  assign sw_inc_d = lives_reset ? 1'b0 : sw_inc;
  assign sw_dec_d = lives_reset ? 1'b0 : sw_dec;
  assign inc_edge = sw_inc & ~sw_inc_q;
  assign dec_edge = sw_dec & ~sw_dec_q;

  // Out-of-range selects match no player.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      sel[i] = (int'(dbg_sel) == i);
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_slot
    lives_player_slot #(
      .LIVES_W      (LIVES_W),
      .MAX_LIVES    (MAX_LIVES),
      .INIT_LIVES   (INIT_LIVES),
      .INVULN_FRAMES(INVULN_FRAMES),
      .CNT_W        (CNT_W)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .clr        (lives_reset),
      .sof        (start_of_frame),
      .freeze     (go_q),
      .inc        (powerup_inc[g]),
      .dbg_inc    (inc_edge & sel[g]),
      .hit        (player_hit[g]),
      .force_dec  (dec_edge & sel[g]),
      .lives_o    (lives[g*LIVES_W +: LIVES_W]),
      .invuln_o   (invulnerable[g]),
      .dead_o     (player_died[g]),
      .dead_next_o(dead_next[g])
    );
  end

  // Decided on next-state deaths so game_over lands with the final death.
  always_comb begin
    go_d    = go_q;
    wv_d    = wv_q;
    wid_d   = wid_q;
    alive_n = 0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (!dead_next[i])
        alive_n = alive_n + 1;
    if (lives_reset) begin
      go_d  = 1'b0;
      wv_d  = 1'b0;
      wid_d = '0;
    end else if (!go_q) begin
      wid_d = '0;
      if (NUM_PLAYERS == 1) begin
        go_d = dead_next[0];
        wv_d = 1'b0;
      end else begin
        go_d = (alive_n <= 1);
        wv_d = (alive_n == 1);
        if (alive_n == 1)
          for (int i = 0; i < NUM_PLAYERS; i++)
            if (!dead_next[i])
              wid_d = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_inc_q <= 1'b0;
      sw_dec_q <= 1'b0;
      go_q     <= 1'b0;
      wv_q     <= 1'b0;
      wid_q    <= '0;
    end else begin
      sw_inc_q <= sw_inc_d;
      sw_dec_q <= sw_dec_d;
      go_q     <= go_d;
      wv_q     <= wv_d;
      wid_q    <= wid_d;
    end
  end

  assign game_over    = go_q;
  assign winner_valid = wv_q;
  assign winner_id    = wid_q;

endmodule

// File: tb/tb_lives_manager.sv
// Self-checking bench for lives_manager (2 players, defaults).
// Expected output vectors are queued when stimulus is driven and compared after the edge.
module tb_lives_manager;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_of_frame = 1'b0;
  logic       lives_reset = 1'b0;
  logic       sw_inc = 1'b0;
  logic       sw_dec = 1'b0;
  logic [0:0] dbg_sel = 1'b0;
  logic [1:0] powerup_inc = 2'b00;
  logic [1:0] player_hit = 2'b00;
  logic [7:0] lives;
  logic [1:0] invulnerable;
  logic [1:0] player_died;
  logic       game_over;
  logic       winner_valid;
  logic [0:0] winner_id;

  lives_manager dut (
    .clk           (clk),
    .reset         (reset),
    .start_of_frame(start_of_frame),
    .lives_reset   (lives_reset),
    .sw_inc        (sw_inc),
    .sw_dec        (sw_dec),
    .dbg_sel       (dbg_sel),
    .powerup_inc   (powerup_inc),
    .player_hit    (player_hit),
    .lives         (lives),
    .invulnerable  (invulnerable),
    .player_died   (player_died),
    .game_over     (game_over),
    .winner_valid  (winner_valid),
    .winner_id     (winner_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [14:0] v;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  wire [14:0] obs = {lives, invulnerable, player_died,
                     game_over, winner_valid, winner_id};

  function automatic logic [14:0] pk(
    input int l1, input int l0,
    input logic [1:0] inv, input logic [1:0] dd,
    input logic go, input logic wv, input logic wid
  );
    return {4'(l1), 4'(l0), inv, dd, go, wv, wid};
  endfunction

  task automatic push(input string t, input logic [14:0] v);
    exp_t x;
    x.tag = t;
    x.v   = v;
    sbq.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      start_of_frame = 1'b1;
      tick();
      start_of_frame = 1'b0;
      tick();
    end
  endtask

  task automatic dec_press(input logic sel);
    dbg_sel = sel;
    sw_dec = 1'b1;
    tick();
    sw_dec = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    push("reset", pk(3, 3, 2'b00, 2'b00, 0, 0, 0));
    tick();
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
  endtask

  task automatic test_hit_invuln();
    player_hit = 2'b01;
    start_of_frame = 1'b1;
    push("hit_p0", pk(3, 2, 2'b01, 2'b00, 0, 0, 0));
    tick();
    player_hit = 2'b00;
    start_of_frame = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
    sof_pulses(5);
    player_hit = 2'b01;
    push("hit_during_invuln", pk(3, 2, 2'b01, 2'b00, 0, 0, 0));
    tick();
    player_hit = 2'b00;
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
    sof_pulses(54);
    push("invuln_after_59_sof", pk(3, 2, 2'b01, 2'b00, 0, 0, 0));
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
    start_of_frame = 1'b1;
    push("invuln_end_60_sof", pk(3, 2, 2'b00, 2'b00, 0, 0, 0));
    tick();
    start_of_frame = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
  endtask

  task automatic test_powerup_sat();
    for (int k = 1; k <= 8; k++) begin
      powerup_inc = 2'b10;
      push($sformatf("powerup_p1_%0d", k),
           pk((3 + k > 9) ? 9 : 3 + k, 2, 2'b00, 2'b00, 0, 0, 0));
      tick();
      powerup_inc = 2'b00;
      e = sbq.pop_front();
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic test_debug_switch();
    for (int k = 1; k <= 2; k++) begin
      dbg_sel = 1'b1;
      sw_dec = 1'b1;
      push($sformatf("sw_dec_p1_%0d", k),
           pk(9 - k, 2, 2'b00, 2'b00, 0, 0, 0));
      tick();
      sw_dec = 1'b0;
      e = sbq.pop_front();
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
      end
      tick();
    end
    sw_inc = 1'b1;
    push("sw_inc_first", pk(8, 2, 2'b00, 2'b00, 0, 0, 0));
    tick();
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
    repeat (99) tick();
    push("sw_inc_held", pk(8, 2, 2'b00, 2'b00, 0, 0, 0));
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
    sw_inc = 1'b0;
    tick();
  endtask

  task automatic test_death_winner();
    repeat (7) dec_press(1'b1);
    push("p1_at_one", pk(1, 2, 2'b00, 2'b00, 0, 0, 0));
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
    player_hit = 2'b10;
    push("p1_dies_winner0", pk(0, 2, 2'b00, 2'b10, 1, 1, 0));
    tick();
    player_hit = 2'b00;
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
    player_hit = 2'b11;
    powerup_inc = 2'b11;
    push("frozen_after_go", pk(0, 2, 2'b00, 2'b10, 1, 1, 0));
    tick();
    player_hit = 2'b00;
    powerup_inc = 2'b00;
    tick();
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
  endtask

  task automatic test_draw();
    lives_reset = 1'b1;
    push("lives_reset_1", pk(3, 3, 2'b00, 2'b00, 0, 0, 0));
    tick();
    lives_reset = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
    repeat (2) dec_press(1'b0);
    repeat (2) dec_press(1'b1);
    player_hit = 2'b11;
    push("draw", pk(0, 0, 2'b00, 2'b11, 1, 0, 0));
    tick();
    player_hit = 2'b00;
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
    lives_reset = 1'b1;
    push("lives_reset_2", pk(3, 3, 2'b00, 2'b00, 0, 0, 0));
    tick();
    lives_reset = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
  endtask

  task automatic test_invuln_combo();
    player_hit = 2'b01;
    tick();
    player_hit = 2'b00;
    powerup_inc = 2'b01;
    push("p0_back_to_3_invuln", pk(3, 3, 2'b01, 2'b00, 0, 0, 0));
    tick();
    powerup_inc = 2'b00;
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
    dbg_sel = 1'b0;
    sw_dec = 1'b1;
    player_hit = 2'b01;
    powerup_inc = 2'b01;
    push("dec_hit_pu_invuln", pk(3, 3, 2'b01, 2'b00, 0, 0, 0));
    tick();
    sw_dec = 1'b0;
    player_hit = 2'b00;
    powerup_inc = 2'b00;
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
    tick();
  endtask

  task automatic test_reset_mid_invuln();
    sof_pulses(30);
    reset = 1'b1;
    #1;
    push("async_reset", pk(3, 3, 2'b00, 2'b00, 0, 0, 0));
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
    tick();
    reset = 1'b0;
    tick();
    player_hit = 2'b01;
    tick();
    player_hit = 2'b00;
    sof_pulses(59);
    push("cnt_cleared_59", pk(3, 2, 2'b01, 2'b00, 0, 0, 0));
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
    start_of_frame = 1'b1;
    push("cnt_cleared_60", pk(3, 2, 2'b00, 2'b00, 0, 0, 0));
    tick();
    start_of_frame = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
  endtask

  initial begin
    test_reset();
    test_hit_invuln();
    test_powerup_sat();
    test_debug_switch();
    test_death_winner();
    test_draw();
    test_invuln_combo();
    test_reset_mid_invuln();
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
